// File: rtl/sipp_scoreboard_rf_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
// Default parameter values live here so the top and its cells agree.
package sipp_scoreboard_rf_pkg;

    localparam int SB_N_ELEMENTS = 16;
    localparam int SB_ADDR_WIDTH = 4;
    localparam int SB_DATA_WIDTH = 16;
    localparam int SB_N_RD       = 2;
    localparam int SB_BYPASS     = 1;
    localparam int SB_ZERO_REG   = 0;

    // Bits needed to represent 'value' distinct codes (0 .. value-1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sipp_sb_bit.sv
// Pending-bit cell for one register: set by a reservation, cleared by a write,
// and flags a reservation that lands on an already-pending register.
module sipp_sb_bit
    import sipp_scoreboard_rf_pkg::*;
#(
    parameter int BYPASS = SB_BYPASS
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pend,
    output logic pend_vis,
    output logic collide
);

    localparam logic BYPASS_EN = (BYPASS != 0);

    logic pend_q;
    logic pend_d;

    always_comb begin
        // NOTE: default assigned first so every path drives pend_d and no latch is inferred.
        pend_d = pend_q;
        if (clr) pend_d = 1'b0;
        if (set) pend_d = 1'b1;  // reservation wins over a same-cycle write
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignment so all flops sample pre-edge values.
        if (!rst) pend_q <= 1'b0;
        else      pend_q <= pend_d;
    end

    assign pend     = pend_q;
    assign pend_vis = pend_q & ~(BYPASS_EN & clr);
    assign collide  = set & pend_q & ~clr;

endmodule

// File: rtl/sipp_scoreboard_rf.sv
// Register file with per-register pending (scoreboard) bits, multi-port
// combinational reads, optional write-to-read forwarding and optional zero register.
module sipp_scoreboard_rf
    import sipp_scoreboard_rf_pkg::*;
#(
    parameter int N_ELEMENTS = SB_N_ELEMENTS,
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int N_RD       = SB_N_RD,
    parameter int BYPASS     = SB_BYPASS,
    parameter int ZERO_REG   = SB_ZERO_REG
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_RD*ADDR_WIDTH-1:0]     rd_addr,
    input  logic [N_RD-1:0]                rd_en,
    output logic [N_RD*DATA_WIDTH-1:0]     rd_data,
    output logic [N_RD-1:0]                rd_busy,
    input  logic [ADDR_WIDTH-1:0]          w_addr,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic                           w_wr,
    input  logic [ADDR_WIDTH-1:0]          rsv_addr,
    input  logic                           rsv_en,
    output logic [ADDR_WIDTH:0]            pend_cnt,
    output logic                           rsv_err
);

    localparam int   CNT_W     = clog2(N_ELEMENTS + 1);
    localparam logic BYPASS_EN = (BYPASS != 0);

    // An address is live if it names a real register that is not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (int'(a) < N_ELEMENTS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    logic                  w_ok;
    logic                  rsv_ok;
    logic [N_ELEMENTS-1:0] set_vec;
    logic [N_ELEMENTS-1:0] clr_vec;
    logic [N_ELEMENTS-1:0] pend;
    logic [N_ELEMENTS-1:0] pend_vis;
    logic [N_ELEMENTS-1:0] collide;
    logic [DATA_WIDTH-1:0] mem_q [N_ELEMENTS];
    logic [DATA_WIDTH-1:0] mem_d [N_ELEMENTS];
    logic                  rsv_err_q;
    logic                  rsv_err_d;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] ra;

    // Reset gates both strobes so nothing is stored or forwarded while rst is low.
    assign w_ok   = rst & w_wr   & addr_ok(w_addr);
    assign rsv_ok = rst & rsv_en & addr_ok(rsv_addr);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int i = 0; i < N_ELEMENTS; i++) begin
            set_vec[i] = rsv_ok && (rsv_addr == ADDR_WIDTH'(i));
            clr_vec[i] = w_ok   && (w_addr   == ADDR_WIDTH'(i));
        end
    end

    for (genvar i = 0; i < N_ELEMENTS; i++) begin : g_reg
        sipp_sb_bit #(
            .BYPASS (BYPASS)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .set      (set_vec[i]),
            .clr      (clr_vec[i]),
            .pend     (pend[i]),
            .pend_vis (pend_vis[i]),
            .collide  (collide[i])
        );
    end

    always_comb begin
        for (int i = 0; i < N_ELEMENTS; i++) begin
            mem_d[i] = clr_vec[i] ? w_data : mem_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the storage array is reset because reads must return zero immediately on reset.
        if (!rst) begin
            for (int i = 0; i < N_ELEMENTS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int k = 0; k < N_RD; k++) begin
            ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (rd_en[k] && addr_ok(ra)) begin
                for (int i = 0; i < N_ELEMENTS; i++) begin
                    if (ra == ADDR_WIDTH'(i)) begin
                        rd_data[k*DATA_WIDTH +: DATA_WIDTH] =
                            (BYPASS_EN && clr_vec[i]) ? w_data : mem_q[i];
                        rd_busy[k] = pend_vis[i];
                    end
                end
            end
        end
    end

    assign rsv_err_d = |collide;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rsv_err_q <= 1'b0;
        else      rsv_err_q <= rsv_err_d;
    end

    assign rsv_err = rsv_err_q;

    // Count is derived from the pend flops, so it tracks them exactly and clears with them.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N_ELEMENTS; i++) begin
            cnt = cnt + CNT_W'(pend[i]);
        end
    end

    assign pend_cnt = (ADDR_WIDTH+1)'(cnt);

endmodule

// File: tb/tb_sipp_scoreboard_rf.sv
// Bench for sipp_scoreboard_rf: two configurations driven in lockstep and
// compared against an array-based reference model of the register-file rules.
module tb_sipp_scoreboard_rf;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  rd_addr = '0;
    logic [1:0]  rd_en = '0;
    logic [3:0]  w_addr = '0;
    logic [15:0] w_data = '0;
    logic        w_wr = 1'b0;
    logic [3:0]  rsv_addr = '0;
    logic        rsv_en = 1'b0;

    logic [31:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [4:0]  cnt_a, cnt_b;
    logic        err_a, err_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Default configuration: 16 regs, forwarding on, no zero register.
    sipp_scoreboard_rf dut_a (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data_a),
        .rd_busy  (rd_busy_a),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_wr     (w_wr),
        .rsv_addr (rsv_addr),
        .rsv_en   (rsv_en),
        .pend_cnt (cnt_a),
        .rsv_err  (err_a)
    );

    // Alternate configuration: 12 regs, no forwarding, hardwired zero register.
    sipp_scoreboard_rf #(
        .N_ELEMENTS (12),
        .BYPASS     (0),
        .ZERO_REG   (1)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_en    (rd_en),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_wr     (w_wr),
        .rsv_addr (rsv_addr),
        .rsv_en   (rsv_en),
        .pend_cnt (cnt_b),
        .rsv_err  (err_b)
    );

    // ---------------- reference model ----------------
    int          ne  [2] = '{16, 12};
    bit          byp [2] = '{1'b1, 1'b0};
    bit          zr  [2] = '{1'b0, 1'b1};
    logic [15:0] m_mem  [2][16];
    bit          m_pend [2][16];
    bit          m_err  [2];

    function automatic bit ok(int d, int a);
        return (a < ne[d]) && !(zr[d] && a == 0);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_err[d] = 1'b0;
            for (int i = 0; i < 16; i++) begin
                m_mem[d][i]  = '0;
                m_pend[d][i] = 1'b0;
            end
        end
    endtask

    function automatic bit fwd_hit(int d, int a);
        return rst && byp[d] && w_wr && (int'(w_addr) == a);
    endfunction

    function automatic logic [15:0] exp_data(int d, int a, bit en);
        if (!en || !ok(d, a)) return 16'h0;
        if (fwd_hit(d, a))    return w_data;
        return m_mem[d][a];
    endfunction

    function automatic logic exp_busy(int d, int a, bit en);
        if (!en || !ok(d, a)) return 1'b0;
        return m_pend[d][a] && !fwd_hit(d, a);
    endfunction

    function automatic int exp_cnt(int d);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_pend[d][i]);
        return n;
    endfunction

    task automatic model_clock();
        bit ws, rs, e;
        if (!rst) return;
        for (int d = 0; d < 2; d++) begin
            ws = w_wr && ok(d, int'(w_addr));
            rs = rsv_en && ok(d, int'(rsv_addr));
            e  = rs && m_pend[d][rsv_addr] && !(ws && w_addr == rsv_addr);
            if (ws) begin
                m_mem[d][w_addr]  = w_data;
                m_pend[d][w_addr] = 1'b0;
            end
            if (rs) m_pend[d][rsv_addr] = 1'b1;
            m_err[d] = e;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] od;
        logic        ob;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                od = (d == 0) ? rd_data_a[k*16 +: 16] : rd_data_b[k*16 +: 16];
                ob = (d == 0) ? rd_busy_a[k] : rd_busy_b[k];
                check($sformatf("dut%0d.rd_data[%0d]", d, k), 32'(od),
                      32'(exp_data(d, int'(rd_addr[k*4 +: 4]), rd_en[k])));
                check($sformatf("dut%0d.rd_busy[%0d]", d, k), 32'(ob),
                      32'(exp_busy(d, int'(rd_addr[k*4 +: 4]), rd_en[k])));
            end
            check($sformatf("dut%0d.pend_cnt", d), 32'((d == 0) ? cnt_a : cnt_b), 32'(exp_cnt(d)));
            check($sformatf("dut%0d.rsv_err", d), 32'((d == 0) ? err_a : err_b), 32'(m_err[d]));
        end
    endtask

    task automatic drive(input logic [3:0] a0, input logic [3:0] a1, input logic [1:0] en,
                         input logic wwr, input logic [3:0] wa, input logic [15:0] wd,
                         input logic rs, input logic [3:0] ra);
        rd_addr  = {a1, a0};
        rd_en    = en;
        w_wr     = wwr;
        w_addr   = wa;
        w_data   = wd;
        rsv_en   = rs;
        rsv_addr = ra;
    endtask

    task automatic settle();
        #2;
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();

        // Reset held: forwarding and storage must stay invisible.
        drive(4'd3, 4'd5, 2'b11, 1'b1, 4'd3, 16'hDEAD, 1'b1, 4'd5);
        settle();
        check("reset_rd_data", rd_data_a, 32'h0);
        check("reset_busy", 32'(rd_busy_a), 32'h0);
        tick();
        rst = 1'b1;

        // Write r5, then read it on both ports.
        drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0);
        step();
        drive(4'd5, 4'd5, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        settle();
        check("r5_port0", 32'(rd_data_a[15:0]), 32'h1234);
        check("r5_port1", 32'(rd_data_a[31:16]), 32'h1234);
        tick();

        // Same-cycle write/read of r3: forwarded on dut_a, old value on dut_b.
        drive(4'd3, 4'd0, 2'b01, 1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0);
        settle();
        check("bypass_on", 32'(rd_data_a[15:0]), 32'hBEEF);
        check("bypass_off", 32'(rd_data_b[15:0]), 32'h0);
        tick();
        drive(4'd3, 4'd3, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        step();

        // Reserve r7 and r9, then retire r7.
        drive(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b1, 4'd7);
        step();
        drive(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b1, 4'd9);
        step();
        drive(4'd7, 4'd9, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        settle();
        check("two_pending_cnt", 32'(cnt_a), 32'd2);
        check("two_pending_busy", 32'(rd_busy_a), 32'h3);
        tick();
        drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd7, 16'h0042, 1'b0, 4'd0);
        step();
        drive(4'd7, 4'd9, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        settle();
        check("retire_cnt", 32'(cnt_a), 32'd1);
        check("retire_busy7", 32'(rd_busy_a[0]), 32'h0);
        tick();

        // Double reservation of r4 raises a one-cycle error.
        drive(4'd0, 4'd0, 2'b00, 1'b0, 4'd0, 16'h0, 1'b1, 4'd4);
        step();
        step();
        drive(4'd4, 4'd0, 2'b01, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        settle();
        check("rsv_err_pulse", 32'(err_a), 32'h1);
        tick();
        settle();
        check("rsv_err_clear", 32'(err_a), 32'h0);
        tick();

        // Reserve and write r6 in one cycle: data lands, reservation wins.
        drive(4'd0, 4'd0, 2'b00, 1'b1, 4'd6, 16'h0011, 1'b1, 4'd6);
        step();
        drive(4'd6, 4'd6, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        settle();
        check("rsv_wr_data", 32'(rd_data_a[15:0]), 32'h0011);
        check("rsv_wr_busy", 32'(rd_busy_a[0]), 32'h1);
        tick();

        // Zero register and out-of-range addresses on dut_b.
        drive(4'd0, 4'd13, 2'b11, 1'b1, 4'd0, 16'hAAAA, 1'b1, 4'd13);
        step();
        drive(4'd0, 4'd13, 2'b11, 1'b1, 4'd14, 16'h5555, 1'b1, 4'd0);
        step();
        drive(4'd0, 4'd14, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        settle();
        check("zero_reg_read", 32'(rd_data_b[15:0]), 32'h0);
        check("oor_read", 32'(rd_data_b[31:16]), 32'h0);
        tick();

        // Asynchronous reset mid-cycle with registers pending.
        drive(4'd9, 4'd4, 2'b11, 1'b1, 4'd9, 16'h7777, 1'b1, 4'd2);
        settle();
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async_rst_cnt", 32'(cnt_a), 32'h0);
        check("async_rst_data", rd_data_a, 32'h0);
        check("async_rst_busy", 32'(rd_busy_a), 32'h0);
        tick();
        rst = 1'b1;
        drive(4'd9, 4'd4, 2'b11, 1'b0, 4'd0, 16'h0, 1'b0, 4'd0);
        step();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                  ($urandom_range(0, 4) < 2), 4'($urandom_range(0, 15)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
